// File: rtl/axi_burst_master_pkg.sv
// Shared types and AXI constants for the burst master.
package axi_burst_master_pkg;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  // AxSIZE encoding for a full-width beat
  function automatic logic [2:0] axi_size(input int data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/axi_burst_len_chk.sv
// Command legality check: beat count limit, plus 4 KB crossing when AXI_4K_CHECK_EN is defined.
module axi_burst_len_chk
  import axi_burst_master_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        len,
  output logic              err
);

  logic len_bad;
  assign len_bad = int'(len) > (MAX_BURST_LEN - 1);

`ifdef AXI_4K_CHECK_EN
  localparam int SIZE = int'(axi_size(DATA_W));

  logic [ADDR_W:0] span;
  logic [ADDR_W:0] last_byte;

  // one extra bit so a burst running off the top of the address space counts as a crossing
  assign span      = ({{(ADDR_W-7){1'b0}}, len} + (ADDR_W+1)'(1)) << SIZE;
  assign last_byte = {1'b0, addr} + span - (ADDR_W+1)'(1);
  assign err       = len_bad | (last_byte[ADDR_W:12] != {1'b0, addr[ADDR_W-1:12]});
`else
  logic unused_addr;
  assign unused_addr = ^addr;
  assign err         = len_bad;
`endif

endmodule

// File: rtl/axi_burst_master.sv
// AXI4 master running independent INCR write and read bursts from user commands.
// Optional 4 KB boundary rejection via AXI_4K_CHECK_EN.
module axi_burst_master
  import axi_burst_master_pkg::*;
#(
  parameter int                ADDR_W        = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = ADDR_W'(32'h4000_0000),
  parameter int                DATA_W        = 32,
  parameter int                ID_W          = 1,
  parameter int                MAX_BURST_LEN = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  // write command / data
  input  logic                  wr_req,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [7:0]            wr_len,
  output logic                  wr_busy,
  input  logic                  wr_dvalid,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  wr_dready,
  output logic                  wr_done,
  output logic                  wr_err,
  // read command / data
  input  logic                  rd_req,
  input  logic [ADDR_W-1:0]     rd_addr,
  input  logic [7:0]            rd_len,
  output logic                  rd_busy,
  output logic                  rd_valid,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_last,
  input  logic                  rd_ready,
  output logic                  rd_done,
  output logic                  rd_err,
  // AXI write address
  output logic [ID_W-1:0]       m_axi_awid,
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic [3:0]            m_axi_awqos,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  // AXI write data
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  // AXI write response
  input  logic [ID_W-1:0]       m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  // AXI read address
  output logic [ID_W-1:0]       m_axi_arid,
  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic [3:0]            m_axi_arqos,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  // AXI read data
  input  logic [ID_W-1:0]       m_axi_rid,
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam logic [2:0] AXI_SIZE = axi_size(DATA_W);

  // constant sidebands
  assign m_axi_awid    = '0;
  assign m_axi_awsize  = AXI_SIZE;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0010;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awqos   = 4'b0000;
  assign m_axi_wstrb   = '1;
  assign m_axi_arid    = '0;
  assign m_axi_arsize  = AXI_SIZE;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0010;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arqos   = 4'b0000;

  logic unused_ids;
  assign unused_ids = ^{m_axi_bid, m_axi_rid};

  logic [ADDR_W-1:0] wr_full, rd_full;
  logic              wr_len_bad, rd_len_bad;

  assign wr_full = BASE_ADDR + wr_addr;
  assign rd_full = BASE_ADDR + rd_addr;

  axi_burst_len_chk #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST_LEN(MAX_BURST_LEN)
  ) u_wr_chk (.addr(wr_full), .len(wr_len), .err(wr_len_bad));

  axi_burst_len_chk #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST_LEN(MAX_BURST_LEN)
  ) u_rd_chk (.addr(rd_full), .len(rd_len), .err(rd_len_bad));

  // ---------------- write engine ----------------
  w_state_t          w_state, w_state_nx;
  logic [ADDR_W-1:0] w_addr_q;
  logic [7:0]        w_len_q, w_cnt;
  logic              w_rej, w_acc, w_hs, w_last;

  assign w_acc         = wr_req & (w_state == W_IDLE);
  assign w_last        = (w_state == W_DATA) & (w_cnt == w_len_q);
  assign wr_busy       = (w_state != W_IDLE);
  assign m_axi_awaddr  = w_addr_q;
  assign m_axi_awlen   = w_len_q;
  assign m_axi_wlast   = w_last;
  assign m_axi_wdata   = (w_state == W_DATA) ? wr_data : '0;
  assign wr_done       = (w_state == W_RESP) & m_axi_bvalid;
  // a rejected command reports err with no done
  assign wr_err        = (wr_done & (m_axi_bresp != AXI_RESP_OKAY)) | w_rej;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state  <= W_IDLE;
      w_addr_q <= '0;
      w_len_q  <= '0;
      w_cnt    <= '0;
      w_rej    <= 1'b0;
    end else begin
      w_state <= w_state_nx;
      w_rej   <= w_acc & wr_len_bad;
      if (w_acc && !wr_len_bad) begin
        w_addr_q <= wr_full;
        w_len_q  <= wr_len;
        w_cnt    <= '0;
      end else if (w_hs) begin
        w_cnt <= w_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    w_state_nx    = w_state;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    wr_dready     = 1'b0;
    m_axi_bready  = 1'b0;
    w_hs          = 1'b0;
    case (w_state)
      W_IDLE: if (w_acc && !wr_len_bad) w_state_nx = W_ADDR;
      W_ADDR: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) w_state_nx = W_DATA;
      end
      W_DATA: begin
        m_axi_wvalid = wr_dvalid;
        wr_dready    = m_axi_wready;
        w_hs         = wr_dvalid & m_axi_wready;
        if (w_hs && w_last) w_state_nx = W_RESP;
      end
      W_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) w_state_nx = W_IDLE;
      end
      default: w_state_nx = W_IDLE;
    endcase
  end

  // ---------------- read engine ----------------
  r_state_t          r_state, r_state_nx;
  logic [ADDR_W-1:0] r_addr_q;
  logic [7:0]        r_len_q, r_cnt;
  logic              r_acc, r_in_data, r_hs, r_end, r_beat_err;
  logic              r_sticky, r_done_q, r_err_q;

  assign r_acc        = rd_req & (r_state == R_IDLE);
  assign r_in_data    = (r_state == R_DATA);
  assign r_hs         = r_in_data & m_axi_rvalid & rd_ready;
  // stop on whichever comes first: slave RLAST or our own beat count
  assign r_end        = r_hs & (m_axi_rlast | (r_cnt == r_len_q));
  assign r_beat_err   = (m_axi_rresp != AXI_RESP_OKAY) | (m_axi_rlast & (r_cnt != r_len_q));
  assign rd_busy      = (r_state != R_IDLE);
  assign rd_valid     = r_in_data & m_axi_rvalid;
  assign rd_data      = r_in_data ? m_axi_rdata : '0;
  assign rd_last      = r_in_data & m_axi_rlast;
  assign rd_done      = r_done_q;
  assign rd_err       = r_err_q;
  assign m_axi_araddr = r_addr_q;
  assign m_axi_arlen  = r_len_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= R_IDLE;
      r_addr_q <= '0;
      r_len_q  <= '0;
      r_cnt    <= '0;
      r_sticky <= 1'b0;
      r_done_q <= 1'b0;
      r_err_q  <= 1'b0;
    end else begin
      r_state  <= r_state_nx;
      r_done_q <= r_end;
      r_err_q  <= (r_end & (r_sticky | r_beat_err)) | (r_acc & rd_len_bad);
      if (r_acc && !rd_len_bad) begin
        r_addr_q <= rd_full;
        r_len_q  <= rd_len;
        r_cnt    <= '0;
        r_sticky <= 1'b0;
      end else if (r_hs) begin
        r_cnt    <= r_cnt + 8'd1;
        r_sticky <= r_sticky | r_beat_err;
      end
    end
  end

  always_comb begin
    r_state_nx    = r_state;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    case (r_state)
      R_IDLE: if (r_acc && !rd_len_bad) r_state_nx = R_ADDR;
      R_ADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) r_state_nx = R_DATA;
      end
      R_DATA: begin
        m_axi_rready = rd_ready;
        if (r_end) r_state_nx = R_IDLE;
      end
      default: r_state_nx = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Randomized bench for axi_burst_master: reactive AXI slave plus burst-level expectations.
module tb_axi_burst_master;

  localparam int          ADDR_W = 32;
  localparam int          DATA_W = 32;
  localparam int          ID_W   = 1;
  localparam int          MAXB   = 16;
  localparam logic [31:0] BASE   = 32'h4000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              wr_req = 0, wr_dvalid = 0, rd_req = 0, rd_ready = 0;
  logic [31:0]       wr_addr = 0, rd_addr = 0, wr_data = 0;
  logic [7:0]        wr_len = 0, rd_len = 0;
  logic              wr_busy, wr_dready, wr_done, wr_err;
  logic              rd_busy, rd_valid, rd_last, rd_done, rd_err;
  logic [31:0]       rd_data;

  logic [ID_W-1:0]   awid, arid;
  logic [31:0]       awaddr, araddr, wdata;
  logic [7:0]        awlen, arlen;
  logic [2:0]        awsize, arsize, awprot, arprot;
  logic [1:0]        awburst, arburst;
  logic              awlock, arlock, awvalid, arvalid, wlast, wvalid, bready, rready;
  logic [3:0]        awcache, arcache, awqos, arqos, wstrb;
  logic              awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0, rlast = 0;
  logic [1:0]        bresp = 0, rresp = 0;
  logic [31:0]       rdata = 0;
  logic [ID_W-1:0]   bid = '0, rid = '0;

  axi_burst_master #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .DATA_W(DATA_W), .ID_W(ID_W),
                     .MAX_BURST_LEN(MAXB)) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_busy(wr_busy),
    .wr_dvalid(wr_dvalid), .wr_data(wr_data), .wr_dready(wr_dready),
    .wr_done(wr_done), .wr_err(wr_err),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_busy(rd_busy),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .rd_ready(rd_ready),
    .rd_done(rd_done), .rd_err(rd_err),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
    .m_axi_awprot(awprot), .m_axi_awqos(awqos), .m_axi_awvalid(awvalid),
    .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
    .m_axi_wready(wready),
    .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
    .m_axi_arprot(arprot), .m_axi_arqos(arqos), .m_axi_arvalid(arvalid),
    .m_axi_arready(arready),
    .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // slave knobs
  int          aw_delay = 0, w_stall = 0, dv_stall = 0, rd_stall = 0;
  int          r_err_beat = -1, r_short = 0;
  logic [1:0]  bresp_cfg = 2'b00;

  // slave observations
  logic [31:0] cap_awaddr = 0, cap_araddr = 0;
  logic [7:0]  cap_awlen = 0, cap_arlen = 0;
  int          aw_cnt = 0, ar_cnt = 0, aw_unstable = 0, w_early = 0;
  logic [31:0] cap_wd[$];
  logic        cap_wl[$];
  logic [31:0] srq[$];
  logic [31:0] erq[$];

  // reactive AXI slave: observe handshakes at negedge, update drives just after posedge
  initial begin
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_open, b_pend, aw_pend_prev;
    int aw_wait, b_wait, r_idx, r_tot, n;
    logic [31:0] prev_awaddr, d;
    logic [7:0]  prev_awlen;
    aw_open = 0; b_pend = 0; aw_pend_prev = 0; aw_wait = 0; b_wait = 0;
    r_idx = 0; r_tot = 0; prev_awaddr = 0; prev_awlen = 0;
    forever begin
      @(negedge clk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      b_hs  = bvalid && bready;
      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;
      if (aw_pend_prev && !(awvalid && awaddr == prev_awaddr && awlen == prev_awlen))
        aw_unstable++;
      aw_pend_prev = awvalid && !awready;
      prev_awaddr  = awaddr;
      prev_awlen   = awlen;
      if (wvalid && !aw_open) w_early++;
      if (aw_hs) begin
        cap_awaddr = awaddr; cap_awlen = awlen; aw_cnt++; aw_open = 1;
      end
      if (w_hs) begin
        cap_wd.push_back(wdata);
        cap_wl.push_back(wlast);
        if (wlast) begin aw_open = 0; b_pend = 1; b_wait = $urandom_range(3); end
      end
      if (ar_hs) begin
        cap_araddr = araddr; cap_arlen = arlen; ar_cnt++;
        n = (r_short > 0) ? r_short : int'(arlen) + 1;
        for (int i = 0; i < n; i++) begin
          d = $urandom;
          srq.push_back(d);
          erq.push_back(d);
        end
        r_tot = n; r_idx = 0;
      end
      if (r_hs) begin
        d = srq.pop_front();
        r_idx++;
      end
      @(posedge clk); #1;
      if (!rst) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rlast = 0;
        rdata = 0; rresp = 0; aw_open = 0; b_pend = 0; aw_wait = 0; aw_pend_prev = 0;
        srq.delete();
        continue;
      end
      if (awvalid) begin
        awready = (aw_wait >= aw_delay);
        aw_wait++;
      end else begin
        awready = 0; aw_wait = 0;
      end
      wready = ($urandom_range(99) >= w_stall);
      if (b_hs) bvalid = 0;
      if (b_pend && !bvalid) begin
        if (b_wait == 0) begin bvalid = 1; bresp = bresp_cfg; b_pend = 0; end
        else b_wait--;
      end
      arready = ($urandom_range(3) != 0);
      if (!(rvalid && !r_hs)) begin
        rvalid = (srq.size() > 0) && ($urandom_range(3) != 0);
        rdata  = (srq.size() > 0) ? srq[0] : 32'h0;
        rlast  = (srq.size() > 0) && (r_idx == r_tot - 1);
        rresp  = (r_idx == r_err_beat) ? 2'b10 : 2'b00;
      end
    end
  end

  task automatic do_write(input logic [31:0] a, input logic [7:0] l, input logic [1:0] br,
                          input bit poke);
    logic [31:0] sent_q[$];
    int t; bit done, took;
    t = 0; done = 0; took = 0;
    cap_wd.delete(); cap_wl.delete(); aw_cnt = 0; aw_unstable = 0; w_early = 0;
    bresp_cfg = br;
    @(posedge clk); #1;
    wr_req = 1; wr_addr = a; wr_len = l;
    @(posedge clk); #1;
    wr_req = 0; wr_addr = $urandom; wr_len = 8'($urandom);
    chk("wr_busy_rise", wr_busy, 1);
    while (!done && t < 1000) begin
      wr_req = (poke && t == 2 && wr_busy);
      if (!wr_dvalid || took) begin
        if (sent_q.size() < int'(l) + 1 && $urandom_range(99) >= dv_stall) begin
          wr_dvalid = 1; wr_data = $urandom;
        end else wr_dvalid = 0;
      end
      @(negedge clk);
      took = wr_dvalid && wr_dready;
      if (took) sent_q.push_back(wr_data);
      if (wr_done) begin
        done = 1;
        chk("wr_err_with_done", wr_err, (br != 2'b00));
      end
      @(posedge clk); #1;
      t++;
    end
    wr_dvalid = 0; wr_req = 0;
    chk("wr_done_seen", done, 1);
    chk("wr_idle_after", wr_busy, 0);
    chk("awaddr", cap_awaddr, 32'(BASE + a));
    chk("awlen", cap_awlen, l);
    chk("aw_count", aw_cnt, 1);
    chk("aw_stable", aw_unstable, 0);
    chk("w_before_aw", w_early, 0);
    chk("w_beats", cap_wd.size(), int'(l) + 1);
    for (int i = 0; i < cap_wd.size() && i < sent_q.size(); i++) begin
      chk("wdata", cap_wd[i], sent_q[i]);
      chk("wlast", cap_wl[i], (i == int'(l)));
    end
  endtask

  task automatic do_read(input logic [31:0] a, input logic [7:0] l, input int err_beat,
                         input int short_n, input bit poke);
    int t, got, n_exp; bit done, exp_err;
    logic [31:0] e;
    t = 0; got = 0; done = 0;
    erq.delete(); ar_cnt = 0; r_err_beat = err_beat; r_short = short_n;
    n_exp   = (short_n > 0) ? short_n : int'(l) + 1;
    exp_err = (err_beat >= 0 && err_beat < n_exp) || (short_n > 0);
    @(posedge clk); #1;
    rd_req = 1; rd_addr = a; rd_len = l;
    @(posedge clk); #1;
    rd_req = 0; rd_addr = $urandom; rd_len = 8'($urandom);
    chk("rd_busy_rise", rd_busy, 1);
    while (!done && t < 1000) begin
      rd_req   = (poke && t == 2 && rd_busy);
      rd_ready = ($urandom_range(99) >= rd_stall);
      @(negedge clk);
      if (rd_valid && rd_ready) begin
        if (erq.size() > 0) begin
          e = erq.pop_front();
          chk("rd_data", rd_data, e);
        end else chk("rd_extra_beat", got, n_exp - 1);
        chk("rd_last", rd_last, (got == n_exp - 1));
        got++;
      end
      if (rd_done) begin
        done = 1;
        chk("rd_err_with_done", rd_err, exp_err);
      end
      @(posedge clk); #1;
      t++;
    end
    rd_ready = 0; rd_req = 0;
    chk("rd_done_seen", done, 1);
    chk("rd_idle_after", rd_busy, 0);
    chk("araddr", cap_araddr, 32'(BASE + a));
    chk("arlen", cap_arlen, l);
    chk("ar_count", ar_cnt, 1);
    chk("rd_beats", got, n_exp);
  endtask

  task automatic do_reject(input bit is_rd, input logic [31:0] a, input logic [7:0] l);
    int errs, dones, axv, busy;
    errs = 0; dones = 0; axv = 0; busy = 0;
    @(posedge clk); #1;
    if (is_rd) begin rd_req = 1; rd_addr = a; rd_len = l; end
    else       begin wr_req = 1; wr_addr = a; wr_len = l; end
    @(posedge clk); #1;
    rd_req = 0; wr_req = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      errs  += int'(is_rd ? rd_err  : wr_err);
      dones += int'(is_rd ? rd_done : wr_done);
      axv   += int'(is_rd ? arvalid : awvalid);
      busy  += int'(is_rd ? rd_busy : wr_busy);
      @(posedge clk); #1;
    end
    chk(is_rd ? "rd_rej_err_pulse" : "wr_rej_err_pulse", errs, 1);
    chk(is_rd ? "rd_rej_no_done" : "wr_rej_no_done", dones, 0);
    chk(is_rd ? "rd_rej_no_axi" : "wr_rej_no_axi", axv, 0);
    chk(is_rd ? "rd_rej_no_busy" : "wr_rej_no_busy", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [7:0]  l, l2;
    int t;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_aw_w_b", {awvalid, wvalid, wlast, bready, wr_dready}, 5'b0);
    chk("rst_ar_r", {arvalid, rready, rd_valid, rd_last}, 4'b0);
    chk("rst_status", {wr_busy, wr_done, wr_err, rd_busy, rd_done, rd_err}, 6'b0);
    chk("rst_addr", {awaddr, araddr}, 64'h0);
    @(posedge clk); #1;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;

    chk("sideband_aw", {awsize, awburst, awcache, awlock, awprot, awqos}, {3'd2, 2'b01, 4'b0010, 1'b0, 3'b0, 4'b0});
    chk("sideband_strb", wstrb, 4'hF);

    aw_delay = 0; w_stall = 0; dv_stall = 0;
    do_write(32'h100, 8'd3, 2'b00, 0);
    aw_delay = 5; w_stall = 50; dv_stall = 20;
    do_write(32'h2000, 8'd7, 2'b00, 1);
    aw_delay = 1; w_stall = 0;
    do_write(32'h40, 8'd0, 2'b10, 0);

    rd_stall = 40;
    do_read(32'h300, 8'd7, -1, 0, 1);
    do_read(32'h80, 8'd3, 2, 0, 0);
    do_read(32'h90, 8'd5, -1, 3, 0);
    rd_stall = 0;
    do_read(32'hA0, 8'd0, -1, 0, 0);

    do_reject(0, 32'h0, 8'd16);
    do_reject(1, 32'h0, 8'd200);
    do_write(32'h500, 8'd15, 2'b00, 0);

`ifdef AXI_4K_CHECK_EN
    do_reject(0, 32'hFF8, 8'd3);
    do_reject(1, 32'hFF8, 8'd3);
    do_write(32'hFF0, 8'd3, 2'b00, 0);
`else
    do_write(32'hFF8, 8'd3, 2'b00, 0);
    do_read(32'hFF8, 8'd3, -1, 0, 0);
`endif

    for (int i = 0; i < 10; i++) begin
      aw_delay = $urandom_range(3); w_stall = $urandom_range(60);
      dv_stall = $urandom_range(60); rd_stall = $urandom_range(60);
      a  = ($urandom & 32'h00FF_F000) | (32'($urandom_range(15)) << 6);
      l  = 8'($urandom_range(15));
      l2 = 8'($urandom_range(15));
      fork
        do_write(a, l, ($urandom_range(3) == 0) ? 2'b11 : 2'b00, 0);
        do_read(a ^ 32'h0001_0000, l2, ($urandom_range(3) == 0) ? int'(l2) : -1, 0, 0);
      join
    end

    // asynchronous reset in the middle of a write data phase
    aw_delay = 0; w_stall = 50; dv_stall = 0;
    @(posedge clk); #1;
    wr_req = 1; wr_addr = 32'h700; wr_len = 8'd7;
    @(posedge clk); #1;
    wr_req = 0; wr_dvalid = 1; wr_data = 32'hDEAD_BEEF;
    t = 0;
    while (!wvalid && t < 50) begin @(posedge clk); #1; t++; end
    chk("rst_reached_wdata", wvalid, 1);
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    chk("midrst_wr", {awvalid, wvalid, wlast, wr_dready, bready, wr_busy, wr_done, wr_err}, 8'b0);
    chk("midrst_rd", {arvalid, rready, rd_busy, rd_valid, rd_done, rd_err}, 6'b0);
    chk("midrst_awaddr", awaddr, 32'h0);
    wr_dvalid = 0;
    @(posedge clk); #1;
    rst = 1;
    repeat (2) @(posedge clk);
    w_stall = 0;
    do_write(32'h800, 8'd2, 2'b00, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
